secure_mode_fsm: RTL and testbench

SECURE_MODE_FSM -- requirements
Module: secure_mode_fsm

---
 rtl/secure_fsm_pkg.sv | 48 ++++
 rtl/secure_mode_fsm_timeout.sv | 30 +++
 rtl/secure_mode_fsm.sv | 102 ++++++++++
 tb/tb_secure_mode_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/secure_fsm_pkg.sv
// Shared state/command encodings and the legal-transition table
// for the secure mode controller.
package secure_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_LOCK = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_CFG    = 3'd1,
        CMD_RUN    = 3'd2,
        CMD_HALT   = 3'd3,
        CMD_RESUME = 3'd4,
        CMD_CLEAR  = 3'd5
    } cmd_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] nxt;
    } xfer_t;

    // Caller must first confirm the full command code is in 0..5.
    function automatic xfer_t legal_next(
        input logic [2:0] st,
        input logic [2:0] c
    );
        xfer_t r;
        r.legal = 1'b1;
        r.nxt   = st;
        unique case (1'b1)
            (c == CMD_NOP): ;
            (st == ST_IDLE && c == CMD_CFG):    r.nxt = ST_CFG;
            (st == ST_CFG  && c == CMD_RUN):    r.nxt = ST_RUN;
            (st == ST_CFG  && c == CMD_CLEAR):  r.nxt = ST_IDLE;
            (st == ST_RUN  && c == CMD_HALT):   r.nxt = ST_HALT;
            (st == ST_HALT && c == CMD_RESUME): r.nxt = ST_RUN;
            (st == ST_HALT && c == CMD_CLEAR):  r.nxt = ST_IDLE;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secure_mode_fsm_timeout.sv
// CFG inactivity timer: expired fires on the edge where the
// count would reach TIMEOUT-1, unless cleared that cycle.
module fsm_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 2);

    logic [W-1:0] cnt;

    assign expired = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/secure_mode_fsm.sv
// Secure mode controller: command-driven FSM with error
// accounting, lockout after MAX_ERR rejects and a CFG timeout.
module secure_mode_fsm
    import secure_fsm_pkg::*;
#(
    parameter int CMD_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int MAX_ERR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd,
    output logic             cmd_ready,
    output logic [2:0]       state_o,
    output logic [3:0]       out,
    output logic             err_o,
    output logic [7:0]       err_cnt,
    output logic             timeout_o,
    output logic             locked_o
);

    localparam logic [7:0] ERR_MAX = 8'(MAX_ERR);
    localparam logic [CMD_W-1:0] CMD_TOP = CMD_W'(5);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       err_d;
    logic       to_d;
    logic [7:0] cnt_d;
    logic       accept;
    logic       cmd_ok;
    logic       st_bad;
    logic       tmo_en;
    logic       tmo_clr;
    logic       tmo_exp;
    xfer_t      xf;

    assign st_bad    = state_q > ST_LOCK;
    assign locked_o  = state_q == ST_LOCK;
    assign cmd_ready = ~locked_o;
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ok    = cmd <= CMD_TOP;
    assign xf        = legal_next(state_q, cmd[2:0]);
    assign state_o   = state_q;
    assign out       = {1'b1, state_q};

    assign tmo_en  = state_q == ST_CFG;
    assign tmo_clr = accept | ~tmo_en;

    fsm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    // Illegal state beats commands; commands beat the timeout.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        cnt_d   = err_cnt;
        if (st_bad) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (accept) begin
            if (cmd_ok && xf.legal) begin
                state_d = xf.nxt;
            end else begin
                err_d = 1'b1;
            end
        end else if (tmo_exp) begin
            state_d = ST_IDLE;
            to_d    = 1'b1;
        end
        if (err_d && err_cnt < ERR_MAX) begin
            cnt_d = err_cnt + 8'd1;
            if (cnt_d == ERR_MAX) begin
                state_d = ST_LOCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_cnt   <= '0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_cnt   <= cnt_d;
            err_o     <= err_d;
            timeout_o <= to_d;
        end
    end

endmodule

// File: tb/tb_secure_mode_fsm.sv
// Scoreboard bench: a table-driven reference model queues expected
// outputs; a negedge monitor pops and compares them.
module tb_secure_mode_fsm;

    localparam int CMD_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int MAX_ERR = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [CMD_W-1:0] cmd = '0;
    logic             cmd_ready;
    logic [2:0]       state_o;
    logic [3:0]       out;
    logic             err_o;
    logic [7:0]       err_cnt;
    logic             timeout_o;
    logic             locked_o;

    always #5 clk = ~clk;

    secure_mode_fsm #(
        .CMD_W   (CMD_W),
        .TIMEOUT (TIMEOUT),
        .MAX_ERR (MAX_ERR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .state_o   (state_o),
        .out       (out),
        .err_o     (err_o),
        .err_cnt   (err_cnt),
        .timeout_o (timeout_o),
        .locked_o  (locked_o)
    );

    typedef struct {
        int st;
        int err;
        int to;
        int ec;
        int rdy;
        int lck;
        int outv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: state number, error count, idle cycles in CFG.
    int m_st = 0;
    int m_ec = 0;
    int m_idle = 0;
    int trans[int];

    function automatic int key(input int s, input int c);
        return s * 64 + c;
    endfunction

    task automatic model_step(input bit rst, input bit v, input int c,
                              output exp_t e);
        int e_err;
        int e_to;
        e_err = 0;
        e_to  = 0;
        if (rst) begin
            m_st = 0;
            m_ec = 0;
        end else if (m_st > 4) begin
            m_st  = 0;
            e_err = 1;
        end else if (v && m_st != 4) begin
            m_idle = 0;
            if (c == 0) begin
                m_st = m_st;
            end else if (trans.exists(key(m_st, c))) begin
                m_st = trans[key(m_st, c)];
            end else begin
                e_err = 1;
            end
        end else if (m_st == 1) begin
            m_idle++;
            if (m_idle == TIMEOUT - 1) begin
                m_st = 0;
                e_to = 1;
            end
        end
        if (e_err == 1 && m_ec < MAX_ERR) begin
            m_ec++;
            if (m_ec == MAX_ERR) m_st = 4;
        end
        if (m_st != 1) m_idle = 0;
        e.st   = m_st;
        e.err  = e_err;
        e.to   = e_to;
        e.ec   = m_ec;
        e.rdy  = (m_st == 4) ? 0 : 1;
        e.lck  = (m_st == 4) ? 1 : 0;
        e.outv = 8 + m_st;
    endtask

    task automatic step(input bit v, input int c);
        exp_t e;
        cmd_valid = v;
        cmd = CMD_W'(c);
        model_step(!rst_n, v, c, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 0);
        rst_n = 1'b1;
    endtask

    // Plant illegal code 6 in the state register between edges.
    task automatic inject_bad();
        @(negedge clk);
        #1;
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        m_st = 6;
    endtask

    function automatic void chk(input string nm, input int act,
                                input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state_o", int'(state_o), e.st);
            chk("err_o", int'(err_o), e.err);
            chk("timeout_o", int'(timeout_o), e.to);
            chk("err_cnt", int'(err_cnt), e.ec);
            chk("cmd_ready", int'(cmd_ready), e.rdy);
            chk("locked_o", int'(locked_o), e.lck);
            chk("out", int'(out), e.outv);
        end
    end

    initial begin
        int c;
        bit v;
        trans[key(0, 1)] = 1;
        trans[key(1, 2)] = 2;
        trans[key(1, 5)] = 0;
        trans[key(2, 3)] = 3;
        trans[key(3, 4)] = 2;
        trans[key(3, 5)] = 0;

        rst_n = 1'b0;
        step(1'b0, 0);
        step(1'b1, 1);
        rst_n = 1'b1;

        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 3);
        step(1'b1, 4);
        step(1'b1, 3);
        step(1'b1, 5);
        step(1'b0, 0);

        do_reset();
        step(1'b1, 6);
        step(1'b1, 7);
        step(1'b0, 0);

        do_reset();
        step(1'b1, 6);
        step(1'b1, 7);
        step(1'b1, 31);
        step(1'b1, 3);
        repeat (3) step(1'b1, 5);
        rst_n = 1'b0;
        step(1'b1, 5);
        rst_n = 1'b1;
        step(1'b0, 0);

        do_reset();
        step(1'b1, 1);
        repeat (15) step(1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 1);
        repeat (14) step(1'b0, 0);
        step(1'b1, 2);
        step(1'b0, 0);

        do_reset();
        inject_bad();
        step(1'b0, 0);
        step(1'b0, 0);

        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 31);
        step(1'b0, 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 7) c = $urandom_range(0, 5);
            else c = $urandom_range(0, 31);
            step(v, c);
            if ($urandom_range(0, 199) == 0) inject_bad();
        end

        rst_n = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
